vu_bus_initiator: RTL

Initiator side of the Vector-06c expansion bus (ВУ): converts single-beat requests into complete bus cycles of status strobe, multiplexed row/column address on ~ШАП with ~RAS/~CAS, memory or I/O read/write strobes, and read-data capture. It is the counterpart of the board's bus sampler, address decoder and ramdisk responder. It lets a host-side FPGA build (bench emulator, loopback rig) drive an expansion board exactly as the Vector CPU does. Optional RAS-only refresh cycles are generated on demand.

---
 rtl/vu_bus_initiator.sv | 283 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/vu_bus_initiator.sv
// vu_bus_initiator: initiator side of the Vector-06c expansion bus.
// Turns single-beat memory/I/O requests into complete bus cycles: status
// strobe, multiplexed row/column address with ~RAS/~CAS, read/write strobes
// and read-data capture. All bus-facing outputs are registered.
// Optional feature macro: VU_REFRESH_EN adds on-demand RAS-only refresh
// cycles with a wrapping 8-bit row counter. Without it refresh_req is ignored
// and refresh_done stays 0.
module vu_bus_initiator #(
  parameter int T_SOST = 2,  // status phase length, 1..15
  parameter int T_RC   = 3,  // ~RAS low to column switch, 1..15
  parameter int T_STB  = 4,  // read/write strobe length, 1..15
  parameter int T_REC  = 2   // recovery with all strobes high, 1..15
) (
  input  logic        clk_cpu,
  input  logic        sys_reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_kind,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  input  logic        req_stack,
  input  logic        refresh_req,
  output logic        refresh_done,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_blk,
  output logic [7:0]  vu_shap_n,
  output logic [7:0]  vu_shavv_n,
  output logic        vu_ras_n,
  output logic        vu_cas_n,
  output logic        vu_zpzu_n,
  output logic        vu_chtzu_n,
  output logic        vu_zpvv_n,
  output logic        vu_chtvv_n,
  output logic        vu_stack,
  output logic        vu_strob_sost,
  output logic [7:0]  vu_shd_o,
  output logic        vu_shd_oe,
  input  logic [7:0]  vu_shd_i,
  input  logic        vu_blk_n
);

  typedef enum logic [2:0] {
    S_IDLE, S_SOST, S_ROW, S_COLSET, S_STROBE, S_RELEASE
  } state_t;

  // Per-cycle context latched at accept (or at refresh start).
  typedef struct packed {
    logic io;    // I/O cycle (no ~RAS/~CAS)
    logic wr;    // write cycle
    logic stk;   // drive СТЕК (memory cycles only)
    logic refc;  // RAS-only refresh cycle
    logic half;  // refresh: second part of the long ~RAS phase
  } ctx_t;

  // Every registered bus/handshake output in one bundle.
  typedef struct packed {
    logic       ras_n;
    logic       cas_n;
    logic       zpzu_n;
    logic       chtzu_n;
    logic       zpvv_n;
    logic       chtvv_n;
    logic       strob_sost;
    logic       stack;
    logic       shd_oe;
    logic       req_ready;
    logic       rsp_valid;
    logic       refresh_done;
    logic [7:0] shap_n;
    logic [7:0] shavv_n;
    logic [7:0] shd_o;
  } out_t;

  localparam out_t OUT_RST = '{
    ras_n: 1'b1, cas_n: 1'b1, zpzu_n: 1'b1, chtzu_n: 1'b1,
    zpvv_n: 1'b1, chtvv_n: 1'b1, strob_sost: 1'b0, stack: 1'b0,
    shd_oe: 1'b0, req_ready: 1'b0, rsp_valid: 1'b0, refresh_done: 1'b0,
    shap_n: 8'hFF, shavv_n: 8'hFF, shd_o: 8'h00
  };

  // Phase counter reload values: counter runs N-1 down to 0.
  localparam logic [3:0] C_SOST = 4'(T_SOST - 1);
  localparam logic [3:0] C_RC   = 4'(T_RC - 1);
  localparam logic [3:0] C_STB  = 4'(T_STB - 1);
  localparam logic [3:0] C_REC  = 4'(T_REC - 1);

  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n;
  ctx_t        ctx, ctx_n;
  logic [15:0] addr_q, addr_n;
  logic [7:0]  wdata_q, wdata_n;
  logic        refresh_pend, pend_n;
  logic [7:0]  row_cnt;
  logic        ref_start, ref_release, capture;
  out_t        out_q, out_d;

  // Next-state, phase counter and context selection.
  // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
  always_comb begin
    state_n     = state;
    cnt_n       = (cnt == 4'd0) ? cnt : cnt - 4'd1;
    ctx_n       = ctx;
    addr_n      = addr_q;
    wdata_n     = wdata_q;
    ref_start   = 1'b0;
    ref_release = 1'b0;
    capture     = 1'b0;
    case (state)
      S_IDLE: begin
        if (refresh_pend) begin
          ref_start = 1'b1;
          state_n   = S_ROW;
          cnt_n     = C_RC;
          ctx_n     = '{io: 1'b0, wr: 1'b0, stk: 1'b0, refc: 1'b1, half: 1'b0};
        end else if (req_valid && req_ready) begin
          state_n = S_SOST;
          cnt_n   = C_SOST;
          ctx_n   = '{io: req_kind[1], wr: req_kind[0],
                      stk: req_stack & ~req_kind[1], refc: 1'b0, half: 1'b0};
          addr_n  = req_addr;
          wdata_n = req_wdata;
        end
      end
      S_SOST: begin
        if (cnt == 4'd0) begin
          state_n = ctx.io ? S_STROBE : S_ROW;
          cnt_n   = ctx.io ? C_STB : C_RC;
        end
      end
      S_ROW: begin
        if (cnt == 4'd0) begin
          if (!ctx.refc) begin
            state_n = S_COLSET;
            cnt_n   = 4'd0;
          end else if (!ctx.half) begin
            // Refresh keeps ~RAS low for T_RC+T_STB: reload once in place.
            ctx_n.half = 1'b1;
            cnt_n      = C_STB;
          end else begin
            ref_release = 1'b1;
            state_n     = S_RELEASE;
            cnt_n       = C_REC;
          end
        end
      end
      S_COLSET: begin
        state_n = S_STROBE;
        cnt_n   = C_STB;
      end
      S_STROBE: begin
        if (cnt == 4'd0) begin
          capture = ~ctx.wr;
          state_n = S_RELEASE;
          cnt_n   = C_REC;
        end
      end
      S_RELEASE: begin
        if (cnt == 4'd0) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Output decode from the upcoming state so every output is a flop.
  always_comb begin
    out_d              = OUT_RST;
    out_d.req_ready    = (state_n == S_IDLE) && !pend_n;
    out_d.rsp_valid    = (state == S_STROBE) && (state_n == S_RELEASE);
    out_d.refresh_done = ref_release;
    case (state_n)
      S_SOST: begin
        out_d.strob_sost = 1'b1;
        out_d.stack      = ctx_n.stk;
        out_d.shd_oe     = ctx_n.wr;
        if (ctx_n.io) out_d.shavv_n = ~addr_n[7:0];
        else          out_d.shap_n  = ~addr_n[7:0];
      end
      S_ROW: begin
        out_d.ras_n  = 1'b0;
        out_d.stack  = ctx_n.stk;
        out_d.shd_oe = ctx_n.wr;
        out_d.shap_n = ctx_n.refc ? ~row_cnt : ~addr_n[7:0];
      end
      S_COLSET: begin
        out_d.ras_n  = 1'b0;
        out_d.stack  = ctx_n.stk;
        out_d.shd_oe = ctx_n.wr;
        out_d.shap_n = ~addr_n[15:8];
      end
      S_STROBE: begin
        out_d.shd_oe = ctx_n.wr;
        if (ctx_n.io) begin
          out_d.shavv_n = ~addr_n[7:0];
          out_d.zpvv_n  = ~ctx_n.wr;
          out_d.chtvv_n = ctx_n.wr;
        end else begin
          out_d.stack   = ctx_n.stk;
          out_d.ras_n   = 1'b0;
          out_d.cas_n   = 1'b0;
          out_d.shap_n  = ~addr_n[15:8];
          out_d.zpzu_n  = ~ctx_n.wr;
          out_d.chtzu_n = ctx_n.wr;
        end
      end
      S_RELEASE: begin
        // I/O port address is held through recovery; memory bus is released.
        if (ctx_n.io) out_d.shavv_n = ~addr_n[7:0];
      end
      default: ;
    endcase
    out_d.shd_o = out_d.shd_oe ? wdata_n : 8'h00;
  end

  // State, counter, context and refresh-pending registers.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_cpu or posedge sys_reset) begin
    if (sys_reset) begin
      state        <= S_IDLE;
      cnt          <= 4'd0;
      ctx          <= '0;
      addr_q       <= 16'h0000;
      wdata_q      <= 8'h00;
      refresh_pend <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      ctx          <= ctx_n;
      addr_q       <= addr_n;
      wdata_q      <= wdata_n;
      refresh_pend <= pend_n;
    end
  end

  // Registered bus outputs and read-data capture.
  // NOTE: capture registers are reset too, since rsp_rdata/rsp_blk are visible outputs.
  always_ff @(posedge clk_cpu or posedge sys_reset) begin
    if (sys_reset) begin
      out_q     <= OUT_RST;
      rsp_rdata <= 8'h00;
      rsp_blk   <= 1'b0;
    end else begin
      out_q <= out_d;
      if (capture) begin
        rsp_rdata <= vu_shd_i;
        rsp_blk   <= ~vu_blk_n;
      end
    end
  end

`ifdef VU_REFRESH_EN
  // Pending pulses collapse into one flag; a pulse on the start cycle re-arms it.
  assign pend_n = (refresh_pend & ~ref_start) | refresh_req;

  // Refresh row counter advances on entry to RELEASE, wrapping 255 -> 0.
  always_ff @(posedge clk_cpu or posedge sys_reset) begin
    if (sys_reset)        row_cnt <= 8'h00;
    else if (ref_release) row_cnt <= row_cnt + 8'd1;
  end
`else
  assign pend_n  = 1'b0;
  assign row_cnt = 8'h00;
  logic unused_refresh;
  assign unused_refresh = refresh_req ^ ref_start;
`endif

  assign req_ready     = out_q.req_ready;
  assign rsp_valid     = out_q.rsp_valid;
  assign refresh_done  = out_q.refresh_done;
  assign vu_shap_n     = out_q.shap_n;
  assign vu_shavv_n    = out_q.shavv_n;
  assign vu_ras_n      = out_q.ras_n;
  assign vu_cas_n      = out_q.cas_n;
  assign vu_zpzu_n     = out_q.zpzu_n;
  assign vu_chtzu_n    = out_q.chtzu_n;
  assign vu_zpvv_n     = out_q.zpvv_n;
  assign vu_chtvv_n    = out_q.chtvv_n;
  assign vu_stack      = out_q.stack;
  assign vu_strob_sost = out_q.strob_sost;
  assign vu_shd_o      = out_q.shd_o;
  assign vu_shd_oe     = out_q.shd_oe;

endmodule
